// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: oversampling UART receiver that
// stores {error, data} entries in a show-ahead FIFO.
module uart_rx_fifo_param #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int LSB_FIRST   = 0,
  parameter int FIFO_WIDTH  = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic [1:0]           Parity_Mode,
  input  logic                 Pop_Data,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic [2:0]           Rx_Error,
  output logic                 Data_Rdy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS
);

  localparam int DIV_RAW = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DVW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW     = $clog2(OVERSAMPLE);
  localparam int BCW     = $clog2(DATA_BITS);
  localparam int DEPTH   = 1 << FIFO_WIDTH;
  localparam int EW      = DATA_BITS + 3;

  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
  localparam logic [OSW-1:0] OS_START = OSW'(OVERSAMPLE / 2 - 2);
  localparam logic [OSW-1:0] OS_BIT   = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DB_LAST  = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] SB_LAST  = BCW'(STOP_BITS - 1);
  localparam logic [FIFO_WIDTH:0] CNT_MAX = (FIFO_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_WIDTH:0] CNT_HI  = (FIFO_WIDTH+1)'(DEPTH/2 + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_PUSH
  } state_e;

  state_e state_q, state_d;

  logic                 rx1_q, rx2_q;
  logic [DVW-1:0]       div_q, div_d;
  logic [OSW-1:0]       os_q, os_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;

  logic tick, detect, samp, push, par_en;

  logic [EW-1:0]         mem_q [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_WIDTH:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [EW-1:0]         hold_q, hold_d, head;
  logic [2:0]            err_w;
  logic                  do_pop, do_wr;

  assign tick   = (div_q == DIV_LAST);
  assign par_en = pmode_q[0] ^ pmode_q[1];

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (detect) state_d = S_START;
      S_START: if (samp) state_d = rx2_q ? S_IDLE : S_DATA;
      S_DATA:
        if (samp && bit_q == DB_LAST)
          state_d = par_en ? S_PAR : S_STOP;
      S_PAR:   if (samp) state_d = S_STOP;
      S_STOP:  if (samp && bit_q == SB_LAST) state_d = S_PUSH;
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    detect = 1'b0;
    samp   = 1'b0;
    push   = 1'b0;
    unique case (state_q)
      S_IDLE:  detect = tick & ~rx2_q;
      S_START: samp = tick & (os_q == OS_START);
      S_DATA,
      S_PAR,
      S_STOP:  samp = tick & (os_q == OS_BIT);
      S_PUSH:  push = 1'b1;
      default: ;
    endcase
  end

  // Detect only fires on a tick, so the divider is already back at 0.
  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    os_d    = os_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pmode_d = pmode_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    if (detect) begin
      os_d    = '0;
      bit_d   = '0;
      pmode_d = Parity_Mode;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      zero_d  = 1'b1;
    end else if (samp) begin
      os_d   = '0;
      zero_d = zero_q & ~rx2_q;
      if (state_q == S_DATA) begin
        bit_d  = (bit_q == DB_LAST) ? '0 : bit_q + 1'b1;
        data_d = (LSB_FIRST != 0)
               ? {rx2_q, data_q[DATA_BITS-1:1]}
               : {data_q[DATA_BITS-2:0], rx2_q};
      end
      if (state_q == S_PAR)
        perr_d = rx2_q ^ (^data_q) ^ pmode_q[1];
      if (state_q == S_STOP) begin
        bit_d = bit_q + 1'b1;
        if (!rx2_q) ferr_d = 1'b1;
      end
    end else if (tick && state_q != S_IDLE) begin
      os_d = os_q + 1'b1;
    end
  end

  assign err_w  = zero_q ? 3'b001 : {ferr_q, perr_q, 1'b0};
  assign do_pop = Pop_Data & (cnt_q != '0);
  assign do_wr  = push & ((cnt_q != CNT_MAX) | do_pop);

  always_comb begin
    wr_d   = do_wr ? wr_q + 1'b1 : wr_q;
    rd_d   = do_pop ? rd_q + 1'b1 : rd_q;
    hold_d = do_pop ? mem_q[rd_q] : hold_q;
    ovf_d  = ovf_q | (push & ~do_wr);
    cnt_d  = cnt_q;
    if (do_wr && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_wr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx1_q   <= 1'b1;
      rx2_q   <= 1'b1;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      pmode_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      rx1_q   <= Rx;
      rx2_q   <= rx1_q;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      pmode_q <= pmode_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && do_wr) mem_q[wr_q] <= {err_w, data_q};
  end

  // An empty FIFO keeps presenting the last entry popped.
  assign head          = FIFO_Empty ? hold_q : mem_q[rd_q];
  assign {Rx_Error, Data_Out} = head;
  assign FIFO_Empty    = (cnt_q == '0);
  assign Data_Rdy      = ~FIFO_Empty;
  assign FIFO_Full     = (cnt_q >= CNT_HI);
  assign RTS           = ~FIFO_Full;
  assign FIFO_Overflow = ovf_q;

endmodule

// File: doc/uart_rx_fifo_param.md
Name: uart_rx_fifo_param

Overview:
Parametrised UART receiver with an integrated receive FIFO. It is the next-generation replacement for the fixed-format receive path. It adds 16x oversampling with mid-bit sampling, a runtime-selectable parity mode, selectable bit order, and per-entry error flags stored alongside the data. It sits between the external Rx pin and the host-side Pop_Data/Data_Out interface, and drives RTS for flow control.

Parameters:
SYSCLK_RATE, 100000000, Clk frequency in Hz
BAUD_RATE, 9600, line rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; even, >=4
DATA_BITS, 8, data bits per frame, 5..9
STOP_BITS, 2, stop bits per frame, 1..2
LSB_FIRST, 0, 0 = data MSB first (current line format), 1 = LSB first
FIFO_WIDTH, 4, log2 of FIFO depth; depth = 2**FIFO_WIDTH

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
Rx  in  1  serial input, asynchronous, idle high
Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none; captured at start-bit detect
Pop_Data  in  1  advance FIFO head by one entry
Data_Out  out  DATA_BITS  head-entry data (show-ahead)
Rx_Error  out  3  head-entry errors: [0] break, [1] parity, [2] frame
Data_Rdy  out  1  equals !FIFO_Empty
FIFO_Empty  out  1  no entries
FIFO_Full  out  1  count >= depth/2 + 1
FIFO_Overflow  out  1  sticky: a frame was dropped
RTS  out  1  equals !FIFO_Full

Behaviour:
- Reset (Rst high at posedge Clk): state IDLE, FIFO count 0, pointers 0, FIFO_Overflow 0, FIFO_Empty 1, Data_Rdy 0, FIFO_Full 0, RTS 1, Data_Out 0, Rx_Error 0, synchroniser flops 1. Reset mid-frame abandons the frame; nothing is written.
- Rx passes through a 2-flop synchroniser. All decoding uses the synchronised value.
- Tick divider: DIV = SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE), minimum 1; one-cycle tick every DIV clocks. The divider restarts at 0 on start-bit detect.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH.
- IDLE: on the first tick with synced Rx = 0, go to START and capture Parity_Mode.
- START: sample at tick OVERSAMPLE/2 - 1. Sample 1 = false start: return to IDLE, no write. Sample 0: go to DATA.
- DATA: sample each bit every OVERSAMPLE ticks, centred mid-bit. Placement: LSB_FIRST=0 places the first bit at [DATA_BITS-1]; LSB_FIRST=1 places it at [0]. After DATA_BITS samples go to PARITY, or to STOP when the mode is none.
- PARITY: even mode expects XOR of data; odd mode expects its inverse. A mismatch sets the parity flag.
- STOP: sample STOP_BITS bits. Any 0 sets the frame flag. After the last stop sample go to PUSH.
- Break: start, all data, parity (if enabled) and all stop samples are 0. Error becomes 3'b001; parity and frame flags are cleared.
- PUSH: lasts exactly one cycle; writes {error, data} to the FIFO, then IDLE. FIFO_Empty deasserts the cycle after PUSH.
- The next start bit may be detected on the first tick after PUSH.
- FIFO is show-ahead: Data_Out and Rx_Error always show the head entry. When empty they hold the last popped value (0 after reset).
- Pop_Data when empty: ignored. Pop_Data held high pops once per cycle.
- Push when count == depth and no pop in the same cycle: the frame is dropped, FIFO_Overflow is set and stays set until Rst, contents are unchanged.
- Push and pop in the same cycle: both are performed and count is unchanged, including when the FIFO is full.
- Pointers wrap modulo depth. Count is FIFO_WIDTH+1 bits wide.
- FIFO_Full and RTS are combinational from count; they update in the cycle after the count change.

Test Plan:
All scenarios use SYSCLK_RATE=16000000, BAUD_RATE=1000000, OVERSAMPLE=16 (DIV=1, 16 clocks/bit), DATA_BITS=8, STOP_BITS=2, FIFO_WIDTH=4.
- Frame 0xA5, even parity (0), stops 11, LSB_FIRST=0 -> Data_Out=0xA5, Rx_Error=000, Data_Rdy=1; Pop_Data pulse -> FIFO_Empty=1.
- 0xAA with parity bit 1, Parity_Mode=01 -> Rx_Error=010, Data_Out=0xAA. Same frame with Parity_Mode=10 -> Rx_Error=000.
- 0xAA, correct parity, stop bits 00 -> Rx_Error=100. All-zero line for 12 bit times, then Rx=1 -> Rx_Error=001, Data_Out=0x00.
- Rx low for 6 clocks then high -> no entry, FIFO_Empty stays 1. A following valid 0x3C frame is received correctly.
- 9 frames 0x00..0x08 with no pops -> FIFO_Full=1 and RTS=0 after the 9th. Continue to 16 entries; a 17th frame (0xFF) -> FIFO_Overflow=1. Popping 16 times returns 0x00..0x0F in order.
- Pop_Data asserted in the same cycle as PUSH with count 16 -> no overflow, count stays 16. Rst asserted mid-DATA -> all outputs return to reset values and no entry is written.
